// File: rtl/xbar_bridge_pkg.sv
// Shared helpers for the bridge response side: one-hot checks and counter sizing.
package xbar_bridge_pkg;

  // Widest ID any bridge instance may use; callers zero-extend into this width.
  localparam int unsigned MAX_ID_W = 64;

  function automatic int unsigned cnt_width(input int unsigned max_ost);
    return (max_ost < 1) ? 1 : $clog2(max_ost + 1);
  endfunction

  function automatic logic is_onehot(input logic [MAX_ID_W-1:0] id);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_ID_W; i++) begin
      ones += 32'(id[i]);
    end
    return (ones == 1);
  endfunction

  function automatic int unsigned onehot_to_index(input logic [MAX_ID_W-1:0] id);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_ID_W; i++) begin
      if (id[i]) begin
        idx = i;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_bridge_ost_counter.sv
// Per-master saturating outstanding-transaction counter with overflow/underflow event flags.
module xbar_bridge_ost_counter #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic at_max,
  output logic nonzero,
  output logic ovf,
  output logic unexp
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // A simultaneous grant and response cancel out and leave the count alone.
  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unexp = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == MAX_CNT) begin
        ovf = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (cnt_q == '0) begin
        unexp = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max  = (cnt_q == MAX_CNT);
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/xbar_bridge_resp_router.sv
// Routes slave responses back to the one-hot-addressed master with one cycle of latency
// and tracks per-master outstanding transactions to drive request-side blocking.
module xbar_bridge_resp_router
  import xbar_bridge_pkg::*;
#(
  parameter int unsigned N_MASTER        = 16,
  parameter int unsigned ID_WIDTH        = N_MASTER,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned AUX_WIDTH       = 6,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_i,
  input  logic [ID_WIDTH-1:0]            req_ID_i,
  input  logic                           data_r_valid_i,
  input  logic [ID_WIDTH-1:0]            data_r_ID_i,
  input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
  input  logic                           data_r_opc_i,
  input  logic [AUX_WIDTH-1:0]           data_r_aux_i,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic [N_MASTER*DATA_WIDTH-1:0] data_r_rdata_o,
  output logic [N_MASTER-1:0]            data_r_opc_o,
  output logic [N_MASTER*AUX_WIDTH-1:0]  data_r_aux_o,
  output logic [N_MASTER-1:0]            req_block_o,
  output logic                           busy_o,
  output logic                           err_id_o,
  output logic                           err_unexp_o,
  output logic                           err_ovf_o
);

  localparam int unsigned CNT_WIDTH = cnt_width(MAX_OUTSTANDING);

  logic req_legal;
  logic resp_legal;
  logic req_bad;
  logic resp_bad;

  logic [N_MASTER-1:0] inc;
  logic [N_MASTER-1:0] dec;
  logic [N_MASTER-1:0] at_max;
  logic [N_MASTER-1:0] nonzero;
  logic [N_MASTER-1:0] ovf;
  logic [N_MASTER-1:0] unexp;

  logic [N_MASTER-1:0]   valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  opc_q;
  logic [AUX_WIDTH-1:0]  aux_q;
  logic                  err_id_q;
  logic                  err_unexp_q;
  logic                  err_ovf_q;

  assign req_legal  = req_valid_i && is_onehot(MAX_ID_W'(req_ID_i));
  assign resp_legal = data_r_valid_i && is_onehot(MAX_ID_W'(data_r_ID_i));
  assign req_bad    = req_valid_i && !req_legal;
  assign resp_bad   = data_r_valid_i && !resp_legal;

  // Illegal IDs never touch the counters.
  assign inc = req_legal  ? N_MASTER'(req_ID_i)    : '0;
  assign dec = resp_legal ? N_MASTER'(data_r_ID_i) : '0;

  for (genvar m = 0; m < N_MASTER; m++) begin : g_cnt
    xbar_bridge_ost_counter #(
      .MAX_OUTSTANDING(MAX_OUTSTANDING),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc[m]),
      .dec    (dec[m]),
      .at_max (at_max[m]),
      .nonzero(nonzero[m]),
      .ovf    (ovf[m]),
      .unexp  (unexp[m])
    );
  end

  // Payload is shared by all masters; only the valid bit selects the recipient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      rdata_q     <= '0;
      opc_q       <= 1'b0;
      aux_q       <= '0;
      err_id_q    <= 1'b0;
      err_unexp_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      valid_q     <= dec;
      if (resp_legal) begin
        rdata_q <= data_r_rdata_i;
        opc_q   <= data_r_opc_i;
        aux_q   <= data_r_aux_i;
      end
      err_id_q    <= req_bad || resp_bad;
      err_unexp_q <= |unexp;
      err_ovf_q   <= |ovf;
    end
  end

  assign data_r_valid_o = valid_q;
  assign data_r_rdata_o = {N_MASTER{rdata_q}};
  assign data_r_opc_o   = {N_MASTER{opc_q}};
  assign data_r_aux_o   = {N_MASTER{aux_q}};
  assign req_block_o    = at_max;
  assign busy_o         = |nonzero;
  assign err_id_o       = err_id_q;
  assign err_unexp_o    = err_unexp_q;
  assign err_ovf_o      = err_ovf_q;

endmodule

// File: tb/tb_xbar_bridge_resp_router.sv
// Directed bench for the response router with a per-cycle reference model of
// outstanding counts and routed responses.
module tb_xbar_bridge_resp_router;

  localparam int NM  = 4;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int MAX = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid_i = 1'b0;
  logic [NM-1:0]   req_ID_i = '0;
  logic            data_r_valid_i = 1'b0;
  logic [NM-1:0]   data_r_ID_i = '0;
  logic [DW-1:0]   data_r_rdata_i = '0;
  logic            data_r_opc_i = 1'b0;
  logic [AW-1:0]   data_r_aux_i = '0;
  logic [NM-1:0]   data_r_valid_o;
  logic [NM*DW-1:0] data_r_rdata_o;
  logic [NM-1:0]   data_r_opc_o;
  logic [NM*AW-1:0] data_r_aux_o;
  logic [NM-1:0]   req_block_o;
  logic            busy_o;
  logic            err_id_o;
  logic            err_unexp_o;
  logic            err_ovf_o;

  int testsRun = 0;
  int testsFailed = 0;

  xbar_bridge_resp_router #(
    .N_MASTER       (NM),
    .ID_WIDTH       (NM),
    .DATA_WIDTH     (DW),
    .AUX_WIDTH      (AW),
    .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ID_i      (req_ID_i),
    .data_r_valid_i(data_r_valid_i),
    .data_r_ID_i   (data_r_ID_i),
    .data_r_rdata_i(data_r_rdata_i),
    .data_r_opc_i  (data_r_opc_i),
    .data_r_aux_i  (data_r_aux_i),
    .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o),
    .data_r_opc_o  (data_r_opc_o),
    .data_r_aux_o  (data_r_aux_o),
    .req_block_o   (req_block_o),
    .busy_o        (busy_o),
    .err_id_o      (err_id_o),
    .err_unexp_o   (err_unexp_o),
    .err_ovf_o     (err_ovf_o)
  );

  always #5 clk = ~clk;

  // Reference model: integer outstanding counts plus the last routed response.
  int            mcnt [NM] = '{default: 0};
  logic [NM-1:0] expValid = '0;
  logic [DW-1:0] expRdata = '0;
  logic          expOpc = 1'b0;
  logic [AW-1:0] expAux = '0;
  logic          expErrId = 1'b0;
  logic          expUnexp = 1'b0;
  logic          expOvf = 1'b0;

  function automatic bit grantOk();
    return req_valid_i && ($countones(req_ID_i) == 1);
  endfunction

  function automatic bit respOk();
    return data_r_valid_i && ($countones(data_r_ID_i) == 1);
  endfunction

  function automatic int modelNext(int m);
    bit g, r;
    g = grantOk() && req_ID_i[m];
    r = respOk() && data_r_ID_i[m];
    if (g && !r && mcnt[m] < MAX) return mcnt[m] + 1;
    if (r && !g && mcnt[m] > 0) return mcnt[m] - 1;
    return mcnt[m];
  endfunction

  function automatic bit modelOvf();
    bit any = 0;
    for (int m = 0; m < NM; m++)
      if (grantOk() && req_ID_i[m] && !(respOk() && data_r_ID_i[m]) && mcnt[m] == MAX) any = 1;
    return any;
  endfunction

  function automatic bit modelUnexp();
    bit any = 0;
    for (int m = 0; m < NM; m++)
      if (respOk() && data_r_ID_i[m] && !(grantOk() && req_ID_i[m]) && mcnt[m] == 0) any = 1;
    return any;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NM; m++) mcnt[m] <= 0;
      expValid <= '0;
      expRdata <= '0;
      expOpc   <= 1'b0;
      expAux   <= '0;
      expErrId <= 1'b0;
      expUnexp <= 1'b0;
      expOvf   <= 1'b0;
    end else begin
      for (int m = 0; m < NM; m++) mcnt[m] <= modelNext(m);
      expValid <= respOk() ? data_r_ID_i : '0;
      if (respOk()) begin
        expRdata <= data_r_rdata_i;
        expOpc   <= data_r_opc_i;
        expAux   <= data_r_aux_i;
      end
      expErrId <= (data_r_valid_i && !respOk()) || (req_valid_i && !grantOk());
      expUnexp <= modelUnexp();
      expOvf   <= modelOvf();
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [NM-1:0] expBlock;
      logic          expBusy;
      expBusy = 1'b0;
      for (int m = 0; m < NM; m++) begin
        expBlock[m] = (mcnt[m] == MAX);
        if (mcnt[m] != 0) expBusy = 1'b1;
      end
      checkOutput("model valid", 128'(data_r_valid_o), 128'(expValid));
      checkOutput("model block", 128'(req_block_o), 128'(expBlock));
      checkOutput("model busy", 128'(busy_o), 128'(expBusy));
      checkOutput("model err_id", 128'(err_id_o), 128'(expErrId));
      checkOutput("model err_unexp", 128'(err_unexp_o), 128'(expUnexp));
      checkOutput("model err_ovf", 128'(err_ovf_o), 128'(expOvf));
      if (expValid != '0) begin
        for (int m = 0; m < NM; m++) begin
          checkOutput("model rdata", 128'(data_r_rdata_o[m*DW +: DW]), 128'(expRdata));
          checkOutput("model opc", 128'(data_r_opc_o[m]), 128'(expOpc));
          checkOutput("model aux", 128'(data_r_aux_o[m*AW +: AW]), 128'(expAux));
        end
      end
    end
  end

  task automatic applyStimulus(input logic qv, input logic [NM-1:0] qid,
                               input logic rv, input logic [NM-1:0] rid,
                               input logic [DW-1:0] rdata, input logic opc,
                               input logic [AW-1:0] aux);
    @(posedge clk);
    #1;
    req_valid_i    = qv;
    req_ID_i       = qid;
    data_r_valid_i = rv;
    data_r_ID_i    = rid;
    data_r_rdata_i = rdata;
    data_r_opc_i   = opc;
    data_r_aux_i   = aux;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic grant(input logic [NM-1:0] id);
    applyStimulus(1'b1, id, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic resp(input logic [NM-1:0] id, input logic [DW-1:0] d, input logic opc, input logic [AW-1:0] aux);
    applyStimulus(1'b0, '0, 1'b1, id, d, opc, aux);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, 128'(data_r_valid_o), 128'(0));
    checkOutput({tag, " rdata"}, 128'(data_r_rdata_o), 128'(0));
    checkOutput({tag, " aux"}, 128'(data_r_aux_o), 128'(0));
    checkOutput({tag, " opc"}, 128'(data_r_opc_o), 128'(0));
    checkOutput({tag, " block"}, 128'(req_block_o), 128'(0));
    checkOutput({tag, " busy"}, 128'(busy_o), 128'(0));
    checkOutput({tag, " errs"}, 128'({err_id_o, err_unexp_o, err_ovf_o}), 128'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Single grant then matching response on master 2.
    grant(4'b0100);
    idle();
    checkOutput("grant busy", 128'(busy_o), 128'(1));
    resp(4'b0100, 32'hDEADBEEF, 1'b1, 6'h2A);
    idle();
    checkOutput("resp valid", 128'(data_r_valid_o), 128'(4'b0100));
    checkOutput("resp rdata2", 128'(data_r_rdata_o[2*DW +: DW]), 128'(32'hDEADBEEF));
    checkOutput("resp busy", 128'(busy_o), 128'(0));
    idle();
    checkOutput("resp pulse", 128'(data_r_valid_o), 128'(0));

    // Saturation on master 1.
    grant(4'b0010);
    grant(4'b0010);
    idle();
    checkOutput("block at max", 128'(req_block_o), 128'(4'b0010));
    grant(4'b0010);
    idle();
    checkOutput("ovf pulse", 128'(err_ovf_o), 128'(1));
    checkOutput("ovf block", 128'(req_block_o), 128'(4'b0010));
    resp(4'b0010, 32'h11112222, 1'b0, 6'h05);
    idle();
    checkOutput("unblock", 128'(req_block_o), 128'(0));
    checkOutput("ovf cleared", 128'(err_ovf_o), 128'(0));
    resp(4'b0010, 32'h33334444, 1'b1, 6'h11);

    // Illegal IDs on both sides.
    resp(4'b0011, 32'hBAD0BAD0, 1'b1, 6'h3F);
    idle();
    checkOutput("multihot valid", 128'(data_r_valid_o), 128'(0));
    checkOutput("multihot err_id", 128'(err_id_o), 128'(1));
    resp(4'b0000, 32'hBAD1BAD1, 1'b0, 6'h01);
    idle();
    checkOutput("zerohot err_id", 128'(err_id_o), 128'(1));
    grant(4'b0110);
    idle();
    checkOutput("bad grant err_id", 128'(err_id_o), 128'(1));
    checkOutput("bad grant busy", 128'(busy_o), 128'(0));

    // Unexpected response still routed.
    resp(4'b1000, 32'h0BADF00D, 1'b0, 6'h12);
    idle();
    checkOutput("unexp valid", 128'(data_r_valid_o), 128'(4'b1000));
    checkOutput("unexp err", 128'(err_unexp_o), 128'(1));
    checkOutput("unexp busy", 128'(busy_o), 128'(0));

    // Simultaneous grant and response, then back-to-back responses.
    grant(4'b0001);
    applyStimulus(1'b1, 4'b0001, 1'b1, 4'b0001, 32'h01234567, 1'b1, 6'h07);
    idle();
    checkOutput("simul valid", 128'(data_r_valid_o), 128'(4'b0001));
    checkOutput("simul busy", 128'(busy_o), 128'(1));
    checkOutput("simul unexp", 128'(err_unexp_o), 128'(0));
    resp(4'b0001, 32'hAAAA0000, 1'b0, 6'h20);
    resp(4'b0100, 32'hBBBB0000, 1'b1, 6'h21);
    checkOutput("b2b first", 128'(data_r_valid_o), 128'(4'b0001));
    checkOutput("b2b first unexp", 128'(err_unexp_o), 128'(0));
    idle();
    checkOutput("b2b second", 128'(data_r_valid_o), 128'(4'b0100));
    checkOutput("b2b second rdata", 128'(data_r_rdata_o[0 +: DW]), 128'(32'hBBBB0000));
    checkOutput("b2b second unexp", 128'(err_unexp_o), 128'(1));

    // Asynchronous reset mid-stream.
    grant(4'b0010);
    grant(4'b0010);
    resp(4'b0100, 32'hCAFEF00D, 1'b1, 6'h15);
    idle();
    checkOutput("pre-reset valid", 128'(data_r_valid_o), 128'(4'b0100));
    checkOutput("pre-reset block", 128'(req_block_o), 128'(4'b0010));
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    resp(4'b0010, 32'h55AA55AA, 1'b0, 6'h2B);
    idle();
    checkOutput("post-reset valid", 128'(data_r_valid_o), 128'(4'b0010));
    checkOutput("post-reset unexp", 128'(err_unexp_o), 128'(1));
    checkOutput("post-reset block", 128'(req_block_o), 128'(0));
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/xbar_bridge_resp_router.md
Name: xbar_bridge_resp_router

Overview:
- Response-side companion of the bridge request arbitration tree. Routes each slave response (r_valid, rdata, opc, aux) back to the originating master, selected by a one-hot ID.
- Registers the response for one cycle of latency.
- Keeps a per-master outstanding-transaction counter, fed by the granted requests leaving the tree. Drives a per-master block signal that the request side uses to mask masters at their outstanding limit.

Parameters:
- N_MASTER, 16, number of masters; must be ≥1.
- ID_WIDTH, N_MASTER, ID width; the ID is one-hot, bit m means master m. ID_WIDTH must equal N_MASTER.
- DATA_WIDTH, 32, read-data width.
- AUX_WIDTH, 6, auxiliary sideband width.
- MAX_OUTSTANDING, 4, maximum in-flight transactions per master; must be ≥1.
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), per-master counter width (derived).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  1  granted request handshake on the slave side (data_req_o & data_gnt_i of the tree).
- req_ID_i  input  ID_WIDTH  ID of the granted request.
- data_r_valid_i  input  1  slave response valid.
- data_r_ID_i  input  ID_WIDTH  response ID.
- data_r_rdata_i  input  DATA_WIDTH  response read data.
- data_r_opc_i  input  1  response opcode/error bit.
- data_r_aux_i  input  AUX_WIDTH  response sideband.
- data_r_valid_o  output  N_MASTER  per-master response valid.
- data_r_rdata_o  output  N_MASTER*DATA_WIDTH  per-master read data, packed, master m at [m*DATA_WIDTH +: DATA_WIDTH].
- data_r_opc_o  output  N_MASTER  per-master opcode.
- data_r_aux_o  output  N_MASTER*AUX_WIDTH  per-master sideband, packed.
- req_block_o  output  N_MASTER  master m is at MAX_OUTSTANDING.
- busy_o  output  1  any counter nonzero.
- err_id_o  output  1  one-cycle pulse on an illegal ID.
- err_unexp_o  output  1  one-cycle pulse on a response to a master with zero outstanding.
- err_ovf_o  output  1  one-cycle pulse on a grant to a master already at MAX_OUTSTANDING.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all counters 0, data registers 0.
- Response routing, 1-cycle latency:
  - If data_r_valid_i=1 and data_r_ID_i is exactly one-hot with bit m set, then next cycle data_r_valid_o[m]=1.
  - rdata/opc/aux are captured into a single shared register and broadcast to every master slice.
  - Slices of non-selected masters carry the data but have valid=0.
  - data_r_valid_o is a pulse: each response yields exactly one valid cycle. No back-pressure exists on the response side.
  - Back-to-back responses each produce one pulse, in order, with no bubble.
- Illegal response ID (data_r_valid_i=1 with zero-hot or multi-hot ID):
  - No valid_o bit asserts and no counter changes.
  - err_id_o=1 on the following cycle.
- Illegal req_ID_i with req_valid_i=1: same handling, no counter change, err_id_o pulse. The err_id_o pulses OR together.
- Counter cnt[m] update, per cycle:
  - inc = req_valid_i & req_ID_i[m] (legal ID only).
  - dec = data_r_valid_i & data_r_ID_i[m] (legal ID only).
  - inc & dec: unchanged; this covers a simultaneous grant and response for the same master.
  - inc only: if cnt < MAX_OUTSTANDING, +1; else saturate and pulse err_ovf_o next cycle.
  - dec only: if cnt > 0, −1; else stay at 0, pulse err_unexp_o next cycle, and still route the response.
  - Neither: hold.
- req_block_o[m] = (cnt[m] == MAX_OUTSTANDING), registered; it follows the counter with no extra delay.
- busy_o = OR over m of (cnt[m] != 0), registered.
- Reset asserted mid-operation clears in-flight state immediately. Responses arriving after reset release, with no outstanding count, raise err_unexp_o.
- N_MASTER=1: ID is a single bit, and the only legal value is 1.

Decomposition:
- Shared package xbar_bridge_pkg holds:
  - the onehot-check function (is_onehot);
  - the onehot-to-index function;
  - a localparam helper for CNT_WIDTH.
- Sub-module xbar_bridge_ost_counter: one saturating up/down counter with ovf/unexp flags and an at_max output, instantiated N_MASTER times in a generate loop.

Test Plan:
- N_MASTER=4, MAX_OUTSTANDING=2, reset, then one grant with ID=4'b0100 → cnt[2]=1, busy_o=1. Then a response with ID 4'b0100 and rdata=32'hDEADBEEF → next cycle valid_o=4'b0100, rdata slice 2 = DEADBEEF; cnt[2] returns to 0 and busy_o=0.
- Two grants to master 1 → req_block_o[1]=1. A third grant → err_ovf_o pulse and cnt[1] stays 2. One response → req_block_o[1]=0.
- Response ID 4'b0011, and separately ID 4'b0000 → no valid_o, err_id_o pulse each time, counters unchanged.
- Response to master 3 with cnt[3]=0 → valid_o[3] pulses, err_unexp_o pulses, cnt[3] stays 0.
- With cnt[0]=1, grant and response for master 0 in the same cycle → cnt[0] stays 1 and valid_o[0] pulses. Then back-to-back responses to masters 0 and 2 → consecutive single-cycle pulses in order.
- Assert rst_n low mid-stream with cnt nonzero and a response registered → all outputs 0 immediately (asynchronously); after release, counters are 0.
